mem_xfer_ctrl: RTL
==================

MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SRAM_AW, 11, SRAM word address width.
- RF_IW, 5, register index width; zero-extended onto 32-bit register-file address buses.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, command strobe; sampled in IDLE only.
- op, in, 1, transfer direction: 0 = load (SRAM->RF), 1 = store (RF->SRAM).
- sramBase, in, 11, first SRAM word address.
- rfBase, in, 5, first register index.
- len, in, 4, word count; 0 means 16.
- busy, out, 1, high from the cycle after accept until DONE inclusive.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle abort pulse.
- sramAdrx, out, 11, SRAM address.
- sramNotOutEn, out, 1, SRAM output enable, active low.
- sramRead, out, 1, 1 = read mode, 0 = write.
- rfWriteAdrx, out, 32, register-file write address.
- rfRdAdrx1, out, 32, register-file read port 1 address.
- rfRdAdrx0, out, 32, register-file read port 0 address.
- rfWriteEn, out, 1, register-file write strobe.
- dataMuxSel, out, 2, shared data bus source: 2'b11 = rdRF0, 2'b10 = rdRF1, 2'b0x = high-Z.

Function
REQ-003 The FSM SHALL have states IDLE, LD_ADDR, LD_CAP, ST_DRIVE, ST_WRITE, FIN.
REQ-004 In IDLE with start=1, the block SHALL latch op, sramBase, rfBase and N (N = len, or 16 if len=0); the next state SHALL be LD_ADDR for op=0 and ST_DRIVE for op=1.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 In IDLE and FIN, outputs SHALL hold their safe values: sramRead=1, sramNotOutEn=1, rfWriteEn=0, dataMuxSel=2'b00, all address outputs 0.
REQ-007 LD_ADDR SHALL drive:
- sramAdrx = current SRAM address
- sramRead=1, sramNotOutEn=0, dataMuxSel=2'b00, rfWriteEn=0
REQ-008 LD_CAP SHALL:
- hold the LD_ADDR SRAM outputs
- drive rfWriteEn=1 and rfWriteAdrx = {27'b0, current register index}
REQ-009 ST_DRIVE SHALL drive:
- rfRdAdrx0 = {27'b0, current register index}
- dataMuxSel=2'b11, sramNotOutEn=1, sramRead=1, sramAdrx = current SRAM address
REQ-010 ST_WRITE SHALL hold the ST_DRIVE outputs except sramRead=0; this cycle is the SRAM write, which stores the low 16 bits of the register.
REQ-011 Each word SHALL take exactly 2 cycles.
REQ-012 After LD_CAP or ST_WRITE:
- SRAM address and register index SHALL increment by 1.
- The remaining count SHALL decrement.
- The FSM SHALL return to LD_ADDR/ST_DRIVE while words remain, otherwise go to FIN.
REQ-013 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-014 Latency from the accept edge to the done pulse SHALL be 2N+1 cycles; a new start SHALL be accepted on the cycle after FIN.
REQ-015 Register index SHALL wrap 31->0 unconditionally.
REQ-016 rfRdAdrx1 SHALL be driven 0 in all states.
REQ-017 sramRead SHALL be 0 only in ST_WRITE.
REQ-018 sramNotOutEn=0 SHALL never coincide with dataMuxSel[1]=1.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, the REQ-006 safe outputs, busy=0, done=0, err=0, and clear the latched command and counters.
REQ-020 Reset mid-transfer SHALL abort the transfer with no further writes; words already written SHALL remain.

Configuration
REQ-021 Macro MEM_XFER_BOUNDS_EN SHALL control address-range checking.
REQ-022 With MEM_XFER_BOUNDS_EN defined, a command with sramBase+N-1 > 2047 SHALL NOT start; the block SHALL go IDLE->FIN with err=1 and done=1 in the same cycle, and no SRAM or RF access SHALL occur.
REQ-023 Without MEM_XFER_BOUNDS_EN, the SRAM address SHALL wrap 2047->0 and err SHALL be tied to 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load: op=0, sramBase=0x010, rfBase=3, len=4 -> R3..R6 receive SRAM[0x010..0x013]; done pulses 9 cycles after accept; rfWriteEn high in exactly 4 cycles.
- Store: op=1, sramBase=0x100, rfBase=31, len=2 -> SRAM[0x100]=R31[15:0], SRAM[0x101]=R0[15:0]; sramRead=0 in exactly 2 cycles.
- len=0 -> exactly 16 words moved; done 33 cycles after accept.
- start pulsed while busy -> ignored; the original transfer completes unchanged.
- rst asserted during ST_DRIVE of word 2 of 4 -> outputs safe immediately; only word 1 written; next start works normally.
- sramBase=0x7FF, len=2: with MEM_XFER_BOUNDS_EN -> err=done=1 one cycle after accept with no access; without it -> addresses 0x7FF then 0x000 accessed, err=0.

Source files
------------

// File: rtl/mem_xfer_ctrl.sv
// SRAM <-> register-file block transfer sequencer: moves 1..16 words, two cycles per word.
// Optional macro MEM_XFER_BOUNDS_EN rejects commands whose SRAM range runs past the top address.
module mem_xfer_ctrl #(
    parameter int SRAM_AW = 11,
    parameter int RF_IW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [SRAM_AW-1:0] sramBase,
    input  logic [RF_IW-1:0]   rfBase,
    input  logic [3:0]         len,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SRAM_AW-1:0] sramAdrx,
    output logic               sramNotOutEn,
    output logic               sramRead,
    output logic [31:0]        rfWriteAdrx,
    output logic [31:0]        rfRdAdrx1,
    output logic [31:0]        rfRdAdrx0,
    output logic               rfWriteEn,
    output logic [1:0]         dataMuxSel
);

    typedef enum logic [2:0] {IDLE, LD_ADDR, LD_CAP, ST_DRIVE, ST_WRITE, FIN} state_t;

    state_t               state_q, state_d;
    logic                 op_q, op_d;
    logic [SRAM_AW-1:0]   sram_adr_q, sram_adr_d;
    logic [RF_IW-1:0]     rf_idx_q, rf_idx_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [SRAM_AW-1:0]   sram_adrx_q, sram_adrx_d;
    logic                 noe_q, noe_d, srd_q, srd_d, rfwe_q, rfwe_d;
    logic [31:0]          rf_wa_q, rf_wa_d, rf_ra0_q, rf_ra0_d;
    logic [1:0]           mux_q, mux_d;
    logic [4:0]           n_s;
    logic                 oob_s;
    logic [31:0]          rf_idx_ext_s;

    assign n_s          = (len == 4'd0) ? 5'd16 : {1'b0, len};
    assign rf_idx_ext_s = {{(32-RF_IW){1'b0}}, rf_idx_d};

`ifdef MEM_XFER_BOUNDS_EN
    logic [SRAM_AW:0] last_adr_s;
    // Carry out of the last-word address means the burst would run past the top of SRAM.
    assign last_adr_s = {1'b0, sramBase} + {{(SRAM_AW-4){1'b0}}, n_s} - {{SRAM_AW{1'b0}}, 1'b1};
    assign oob_s      = last_adr_s[SRAM_AW];
`else
    assign oob_s      = 1'b0;
`endif

    // Next-state, command latch and word counter.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sram_adr_d = sram_adr_q;
        rf_idx_d   = rf_idx_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    sram_adr_d = sramBase;
                    rf_idx_d   = rfBase;
                    cnt_d      = n_s;
                    if (oob_s) begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = op ? ST_DRIVE : LD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LD_ADDR:  state_d = LD_CAP;
            ST_DRIVE: state_d = ST_WRITE;
            LD_CAP, ST_WRITE: begin
                sram_adr_d = sram_adr_q + {{(SRAM_AW-1){1'b0}}, 1'b1};
                rf_idx_d   = rf_idx_q + {{(RF_IW-1){1'b0}}, 1'b1};
                cnt_d      = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = FIN;
                end else begin
                    state_d = (state_q == LD_CAP) ? LD_ADDR : ST_DRIVE;
                end
            end
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output values for the state being entered, so the flops line up with the state register.
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        sram_adrx_d = {SRAM_AW{1'b0}};
        noe_d       = 1'b1;
        srd_d       = 1'b1;
        rf_wa_d     = 32'd0;
        rf_ra0_d    = 32'd0;
        rfwe_d      = 1'b0;
        mux_d       = 2'b00;
        case (state_d)
            IDLE: busy_d = 1'b0;
            LD_ADDR: begin
                busy_d      = 1'b1;
                sram_adrx_d = sram_adr_d;
                noe_d       = 1'b0;
            end
            LD_CAP: begin
                busy_d      = 1'b1;
                sram_adrx_d = sram_adr_d;
                noe_d       = 1'b0;
                rfwe_d      = 1'b1;
                rf_wa_d     = rf_idx_ext_s;
            end
            ST_DRIVE, ST_WRITE: begin
                busy_d      = 1'b1;
                sram_adrx_d = sram_adr_d;
                rf_ra0_d    = rf_idx_ext_s;
                mux_d       = 2'b11;
                srd_d       = (state_d == ST_WRITE) ? 1'b0 : 1'b1;
            end
            FIN: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    // State, command and output registers; reset lands every output on its safe value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            sram_adr_q  <= {SRAM_AW{1'b0}};
            rf_idx_q    <= {RF_IW{1'b0}};
            cnt_q       <= 5'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sram_adrx_q <= {SRAM_AW{1'b0}};
            noe_q       <= 1'b1;
            srd_q       <= 1'b1;
            rf_wa_q     <= 32'd0;
            rf_ra0_q    <= 32'd0;
            rfwe_q      <= 1'b0;
            mux_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sram_adr_q  <= sram_adr_d;
            rf_idx_q    <= rf_idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sram_adrx_q <= sram_adrx_d;
            noe_q       <= noe_d;
            srd_q       <= srd_d;
            rf_wa_q     <= rf_wa_d;
            rf_ra0_q    <= rf_ra0_d;
            rfwe_q      <= rfwe_d;
            mux_q       <= mux_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign sramAdrx     = sram_adrx_q;
    assign sramNotOutEn = noe_q;
    assign sramRead     = srd_q;
    assign rfWriteAdrx  = rf_wa_q;
    assign rfRdAdrx0    = rf_ra0_q;
    assign rfRdAdrx1    = 32'd0;
    assign rfWriteEn    = rfwe_q;
    assign dataMuxSel   = mux_q;

endmodule
